// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field positions, fetch FSM states,
// reset PC and the IF/ID payload layout.
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    // Instruction field bit positions
    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 28;
    localparam int unsigned RD_MSB  = 27;
    localparam int unsigned RD_LSB  = 22;
    localparam int unsigned RS_MSB  = 21;
    localparam int unsigned RS_LSB  = 16;
    localparam int unsigned RT_MSB  = 15;
    localparam int unsigned RT_LSB  = 10;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // REQ: request on the bus; WAIT: granted, awaiting rvalid;
    // HOLD: response parked because decode is stalled
    typedef enum logic [1:0] {
        FS_REQ  = 2'd0,
        FS_WAIT = 2'd1,
        FS_HOLD = 2'd2
    } fetch_state_e;

    // Payload held in the IF/ID register and the response buffer
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID holding register: valid/ready handshake towards decode, with flush.
// Flush has priority over load, so a word loaded on a redirect cycle is dropped.
module if_id_reg
    import cpu_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_load,
    input  logic   i_flush,
    input  logic   i_ready,
    input  if_id_t i_data,
    output logic   o_valid,
    output if_id_t o_data,
    output logic   o_can_load_c
);

    logic   r_valid;
    if_id_t r_data;

    // Register is free when empty or when decode consumes it this cycle
    assign o_can_load_c = !r_valid || i_ready;

    // Valid flag and payload; payload keeps its value when not reloaded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, single-outstanding imem request FSM, redirect
// handling with stale-response dropping, and the IF/ID register.
// Optional feature macro: FETCH_STALL_CNT_EN adds the stall_cnt output.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] PC_INC   = 32'd1
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            id_ready,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_inst,
    output logic [3:0]      id_opcode,
    output logic [5:0]      id_rd,
    output logic [5:0]      id_rs,
    output logic [5:0]      id_rt,
    output logic [5:0]      id_imm6
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0]     stall_cnt
`endif
);

    fetch_state_e    r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_out_pc;
    logic            r_req;
    logic            r_stale;
    if_id_t          r_buf;

    logic            w_can_load;
    logic            w_load;
    if_id_t          w_load_data;
    if_id_t          w_id_data;

    // Select what enters IF/ID: a fresh response in WAIT or the parked one in HOLD
    always_comb begin
        w_load      = 1'b0;
        w_load_data = '0;
        if (r_state == FS_WAIT && imem_rvalid && !r_stale && w_can_load) begin
            w_load      = 1'b1;
            w_load_data = '{pc: r_out_pc, inst: imem_rdata};
        end else if (r_state == FS_HOLD && id_ready) begin
            w_load      = 1'b1;
            w_load_data = r_buf;
        end
    end

    // Fetch FSM with PC, request flag and stale-response tracking.
    // A redirect while a response is still owed parks in WAIT with the stale
    // flag set, so only one request is ever outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= FS_REQ;
            r_pc     <= RESET_PC;
            r_out_pc <= '0;
            r_req    <= 1'b0;
            r_stale  <= 1'b0;
            r_buf    <= '0;
        end else begin
            case (r_state)
                FS_REQ: begin
                    r_req <= 1'b1;
                    if (br_taken) begin
                        r_pc <= br_target;
                        if (r_req && imem_gnt) begin
                            // Grant on a redirect cycle belongs to the old path
                            r_state <= FS_WAIT;
                            r_stale <= 1'b1;
                            r_req   <= 1'b0;
                        end
                    end else if (r_req && imem_gnt) begin
                        r_out_pc <= r_pc;
                        r_pc     <= r_pc + PC_INC;
                        r_state  <= FS_WAIT;
                        r_req    <= 1'b0;
                    end
                end
                FS_WAIT: begin
                    if (br_taken) begin
                        r_pc <= br_target;
                        if (imem_rvalid) begin
                            r_state <= FS_REQ;
                            r_req   <= 1'b1;
                            r_stale <= 1'b0;
                        end else begin
                            r_stale <= 1'b1;
                        end
                    end else if (imem_rvalid) begin
                        r_stale <= 1'b0;
                        if (r_stale || w_can_load) begin
                            r_state <= FS_REQ;
                            r_req   <= 1'b1;
                        end else begin
                            r_state <= FS_HOLD;
                            r_buf   <= '{pc: r_out_pc, inst: imem_rdata};
                        end
                    end
                end
                FS_HOLD: begin
                    if (br_taken) begin
                        r_pc    <= br_target;
                        r_state <= FS_REQ;
                        r_req   <= 1'b1;
                    end else if (id_ready) begin
                        r_state <= FS_REQ;
                        r_req   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= FS_REQ;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load       (w_load),
        .i_flush      (br_taken),
        .i_ready      (id_ready),
        .i_data       (w_load_data),
        .o_valid      (id_valid),
        .o_data       (w_id_data),
        .o_can_load_c (w_can_load)
    );

    assign imem_req  = r_req;
    assign imem_addr = r_pc;

    assign id_pc     = w_id_data.pc;
    assign id_inst   = w_id_data.inst;
    assign id_opcode = w_id_data.inst[OPC_MSB:OPC_LSB];
    assign id_rd     = w_id_data.inst[RD_MSB:RD_LSB];
    assign id_rs     = w_id_data.inst[RS_MSB:RS_LSB];
    assign id_rt     = w_id_data.inst[RT_MSB:RT_LSB];
    assign id_imm6   = w_id_data.inst[RT_MSB:RT_LSB];

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Saturating count of cycles where decode holds off a valid instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (id_valid && !id_ready && r_stall_cnt != 16'hFFFF) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameters SHALL be: RESET_PC, 32'h0000_0000, first fetch address after reset; PC_INC, 1, PC increment per instruction (word-addressed memory).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 imem_req  output  1  instruction-memory request, held until granted.
REQ-005 imem_addr  output  32  request address (current PC), stable while imem_req is high.
REQ-006 imem_gnt  input  1  memory accepts the request this cycle.
REQ-007 imem_rvalid  input  1  read data valid; arrives one or more cycles after the grant.
REQ-008 imem_rdata  input  32  instruction word.
REQ-009 br_taken  input  1  redirect pulse from execute.
REQ-010 br_target  input  32  redirect address, sampled when br_taken is high.
REQ-011 id_ready  input  1  decode stage (immediate generator, register file) accepts the instruction.
REQ-012 id_valid  output  1  IF/ID register holds a valid instruction.
REQ-013 id_pc  output  32  PC of the held instruction.
REQ-014 id_inst  output  32  held instruction word.
REQ-015 id_opcode  output  4  id_inst[31:28]; id_rd 6 = [27:22]; id_rs 6 = [21:16]; id_rt 6 = [15:10].
REQ-016 id_imm6  output  6  id_inst[15:10], the raw field that feeds the sign-extending immediate generator.

Function
REQ-017 The FSM SHALL have states REQ (imem_req=1), WAIT (grant done, awaiting rvalid) and HOLD (id_valid=1, id_ready=0, no request outstanding).
REQ-018 REQ->WAIT SHALL occur on imem_gnt; WAIT exits on imem_rvalid to REQ if the IF/ID register can be loaded, or to HOLD otherwise.
REQ-019 The IF/ID register SHALL be loaded one cycle after imem_rvalid and SHALL be loadable when id_valid=0 or id_ready=1 (full throughput).
REQ-020 The PC SHALL advance by PC_INC on each grant; at most one request SHALL be outstanding.
REQ-021 In HOLD, id_* SHALL remain stable and no new request SHALL issue; HOLD->REQ occurs on id_ready.
REQ-022 br_taken SHALL set PC to br_target, clear id_valid the next cycle, and return the FSM to REQ at br_target.
REQ-023 br_taken in WAIT SHALL mark the outstanding response as stale; the stale response SHALL be dropped and SHALL NOT reach id_*.
REQ-024 br_taken coincident with imem_gnt SHALL win: the grant is treated as stale, and the PC becomes br_target rather than PC+PC_INC.
REQ-025 br_taken coincident with id_valid&id_ready SHALL complete that handshake; any newly loaded word SHALL be flushed.
REQ-026 PC arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFF + 1 wraps to 0.

Reset
REQ-027 On rst_n low: state=REQ, PC=RESET_PC, id_valid=0, id_pc/id_inst=0, stale flag=0, imem_req=0, stall_cnt=0.
REQ-028 imem_req SHALL rise on the first clk edge after rst_n deasserts; assertion during WAIT SHALL drop the pending response.

Configuration
REQ-029 With FETCH_STALL_CNT_EN defined, output stall_cnt (16 bits) SHALL count cycles where id_valid=1 and id_ready=0, saturating at 16'hFFFF; without the macro, the port and the logic SHALL be absent.

Structure
REQ-030 Shared package cpu_pkg SHALL hold the field bit positions (OPC_MSB/LSB, RD/RS/RT ranges), the fetch state enum and RESET_PC_DEFAULT.
REQ-031 One sub-module, if_id_reg (valid/ready holding register with flush), is natural; the FSM and PC stay in fetch_stage.

Verification
REQ-032 Reset, imem_gnt=1, rvalid one cycle later with rdata=32'h1234_5678, id_ready=1 -> id_valid=1, id_pc=0, id_opcode=4'h1, id_imm6=6'h15.
REQ-033 id_ready=0 for 5 cycles with a valid instruction -> id_* stable, imem_req=0, stall_cnt=5 (macro on).
REQ-034 br_taken with br_target=32'h40 in WAIT -> stale rdata dropped, next imem_addr=32'h40, id_valid stays 0 until the new response.
REQ-035 RESET_PC=32'hFFFF_FFFF, two grants -> imem_addr sequence FFFF_FFFF, 0000_0000.
REQ-036 rst_n pulsed low in WAIT, then rvalid arrives -> response ignored, id_valid=0, imem_addr=RESET_PC.
